// File: rtl/spi_dac_if.sv
// SPI DAC bus interface.
// Carries the four pins the SPI DAC controller drives towards one DAC channel.
//   bCS    chip select, active low
//   SCK    serial clock, idles low
//   SDI    serial data, MSB first
//   bLDAC  load DAC, active low
// Modports:
//   master  the controller side (drives all pins)
//   slave   the DAC / receiver side (samples all pins)
interface spi_dac_if;
    logic bCS;
    logic SCK;
    logic SDI;
    logic bLDAC;

    modport master (
        output bCS,
        output SCK,
        output SDI,
        output bLDAC
    );

    modport slave (
        input bCS,
        input SCK,
        input SDI,
        input bLDAC
    );
endinterface

// File: rtl/spi_dac_receiver.sv
// SPI target-side receiver modelling one DAC channel.
// The SPI pins are asynchronous to clk. They are oversampled, shifted in
// MSB-first as fixed-length words, and a word is committed only when bCS
// rises after exactly spi_length SCK rising edges. The last committed word is
// copied to the DAC output register on a falling edge of bLDAC.
//
// Ports:
//   clk          fabric clock, at least 4x the SCK frequency
//   rst          asynchronous, active-high reset
//   spi          SPI bus (slave modport): bCS, SCK, SDI, bLDAC
//   rx_data      last correctly framed word
//   rx_valid     1-cycle pulse when rx_data updates
//   dac_out      DAC output register, loaded on bLDAC fall
//   ldac_strobe  1-cycle pulse when dac_out loads
//   frame_err    1-cycle pulse when a frame is discarded
//   frame_cnt    count of committed frames, wraps
module spi_dac_receiver #(
    parameter int spi_length = 16,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_dac_if.slave              spi,
    output logic [spi_length-1:0] rx_data,
    output logic                  rx_valid,
    output logic [spi_length-1:0] dac_out,
    output logic                  ldac_strobe,
    output logic                  frame_err,
    output logic [cnt_width-1:0]  frame_cnt
);

    // Bit counter has to reach spi_length+1 (the overrun marker).
    localparam int BIT_W = $clog2(spi_length + 2);
    localparam logic [BIT_W-1:0] LEN_C = BIT_W'(spi_length);
    localparam logic [BIT_W-1:0] OVR_C = BIT_W'(spi_length + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // _p0/_p1: two-flop synchroniser, _p2: previous synchronised value
    logic cs_p0, cs_p1, cs_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic sdi_p0, sdi_p1, sdi_p2;
    logic ldac_p0, ldac_p1, ldac_p2;

    // _p3: registered edge strobes and the SDI bit aligned with them
    logic cs_rise_p3, cs_fall_p3, sck_rise_p3, ldac_fall_p3;
    logic sdi_p3;

    logic [spi_length-1:0] shift_reg, shift_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [spi_length-1:0] rx_data_nxt, dac_out_nxt;
    logic [cnt_width-1:0]  frame_cnt_nxt;
    logic                  rx_valid_nxt, frame_err_nxt, ldac_strobe_nxt;

    // ---- stage p0..p2: synchronise the asynchronous pins ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_p0   <= 1'b1; cs_p1   <= 1'b1; cs_p2   <= 1'b1;
            sck_p0  <= 1'b0; sck_p1  <= 1'b0; sck_p2  <= 1'b0;
            sdi_p0  <= 1'b0; sdi_p1  <= 1'b0; sdi_p2  <= 1'b0;
            ldac_p0 <= 1'b1; ldac_p1 <= 1'b1; ldac_p2 <= 1'b1;
        end else begin
            cs_p0   <= spi.bCS;   cs_p1   <= cs_p0;   cs_p2   <= cs_p1;
            sck_p0  <= spi.SCK;   sck_p1  <= sck_p0;  sck_p2  <= sck_p1;
            sdi_p0  <= spi.SDI;   sdi_p1  <= sdi_p0;  sdi_p2  <= sdi_p1;
            ldac_p0 <= spi.bLDAC; ldac_p1 <= ldac_p0; ldac_p2 <= ldac_p1;
        end
    end

    // ---- stage p3: register edge strobes ----
    // SDI is captured together with the SCK rise so the FSM sees the bit
    // that was present on the same synchronised cycle as the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_rise_p3   <= 1'b0;
            cs_fall_p3   <= 1'b0;
            sck_rise_p3  <= 1'b0;
            ldac_fall_p3 <= 1'b0;
            sdi_p3       <= 1'b0;
        end else begin
            cs_rise_p3   <= cs_p1 & ~cs_p2;
            cs_fall_p3   <= ~cs_p1 & cs_p2;
            sck_rise_p3  <= sck_p1 & ~sck_p2;
            ldac_fall_p3 <= ~ldac_p1 & ldac_p2;
            sdi_p3       <= sdi_p1;
        end
    end

    // ---- FSM and datapath next-state ----
    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift_reg;
        bit_cnt_nxt     = bit_cnt;
        rx_data_nxt     = rx_data;
        frame_cnt_nxt   = frame_cnt;
        dac_out_nxt     = dac_out;
        rx_valid_nxt    = 1'b0;
        frame_err_nxt   = 1'b0;
        ldac_strobe_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall_p3) begin
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                // A coincident SCK rise is applied before the frame check.
                if (sck_rise_p3) begin
                    shift_nxt = {shift_reg[spi_length-2:0], sdi_p3};
                    if (bit_cnt != OVR_C)
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                end
                if (cs_rise_p3) begin
                    state_nxt = IDLE;
                    if (bit_cnt_nxt == LEN_C) begin
                        rx_data_nxt   = shift_nxt;
                        rx_valid_nxt  = 1'b1;
                        frame_cnt_nxt = frame_cnt + cnt_width'(1);
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // rx_data_nxt already holds the new word on a same-cycle commit.
        if (ldac_fall_p3) begin
            dac_out_nxt     = rx_data_nxt;
            ldac_strobe_nxt = 1'b1;
        end
    end

    // ---- stage p4: FSM state, datapath and registered pulses ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            dac_out     <= '0;
            frame_cnt   <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            ldac_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_data     <= rx_data_nxt;
            dac_out     <= dac_out_nxt;
            frame_cnt   <= frame_cnt_nxt;
            rx_valid    <= rx_valid_nxt;
            frame_err   <= frame_err_nxt;
            ldac_strobe <= ldac_strobe_nxt;
        end
    end

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed bench for spi_dac_receiver: 16-bit frames, 4-bit frame counter so
// the wrap case stays short. SCK runs at clk/16. Inputs change on the falling
// clk edge; outputs are sampled on the falling edge or #1 after a rising edge.
module tb_spi_dac_receiver;

    localparam int L  = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [L-1:0]  rx_data;
    logic          rx_valid;
    logic [L-1:0]  dac_out;
    logic          ldac_strobe;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    // Pulse counters maintained by a monitor
    int n_valid = 0;
    int n_err   = 0;
    int n_ldac  = 0;

    spi_dac_if bus ();

    spi_dac_receiver #(.spi_length(L), .cnt_width(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (bus.slave),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .dac_out     (dac_out),
        .ldac_strobe (ldac_strobe),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)    n_valid++;
        if (frame_err)   n_err++;
        if (ldac_strobe) n_ldac++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // bCS low, then nbits SCK periods carrying word[nbits-1:0] MSB first.
    task automatic shift_bits(input logic [31:0] word, input int nbits);
        @(negedge clk);
        bus.bCS = 1'b0;
        clks(8);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.SDI = word[i];
            clks(8);
            bus.SCK = 1'b1;
            clks(8);
            bus.SCK = 1'b0;
        end
        clks(4);
    endtask

    task automatic end_frame();
        bus.bCS = 1'b1;
        clks(10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rx_data, dac_out, frame_cnt, rx_valid, ldac_strobe, frame_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rx=%h dac=%h cnt=%0d pulses=%b%b%b, need all 0",
                     rx_data, dac_out, frame_cnt, rx_valid, ldac_strobe, frame_err);
        end
    endtask

    task automatic test_good_frame();
        logic [3:0] seen;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        shift_bits(32'hA5C3, 16);
        bus.bCS = 1'b1;
        // Edges E0..E4 after bCS rises at the pin; pulse expected only after E3.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) seen[k] = rx_valid;
            else begin
                checks++;
                if (rx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL t1_pulse_width: rx_valid=%b after E4, need 0", rx_valid);
                end
            end
        end
        checks++;
        if (seen !== 4'b1000) begin
            failures++;
            $display("FAIL t1_latency: rx_valid at E3..E0=%b, need 1000", seen);
        end
        clks(8);
        checks++;
        if (rx_data !== 16'hA5C3) begin
            failures++;
            $display("FAIL t1_rx_data: got %h, need a5c3", rx_data);
        end
        checks++;
        if (frame_cnt !== 4'd1 || (n_valid - v0) != 1 || (n_err - e0) != 0) begin
            failures++;
            $display("FAIL t1_counts: cnt=%0d valid=%0d err=%0d, need 1/1/0",
                     frame_cnt, n_valid - v0, n_err - e0);
        end
        checks++;
        if (dac_out !== 16'h0000) begin
            failures++;
            $display("FAIL t1_dac_idle: got %h, need 0000", dac_out);
        end
    endtask

    task automatic test_ldac();
        int l0;
        l0 = n_ldac;
        @(negedge clk);
        bus.bLDAC = 1'b0;
        clks(64);
        checks++;
        if (dac_out !== 16'hA5C3 || (n_ldac - l0) != 1) begin
            failures++;
            $display("FAIL t2_ldac_load: dac=%h strobes=%0d, need a5c3/1", dac_out, n_ldac - l0);
        end
        bus.bLDAC = 1'b1;
        clks(16);
        bus.bLDAC = 1'b0;
        clks(16);
        bus.bLDAC = 1'b1;
        clks(8);
        checks++;
        if (dac_out !== 16'hA5C3 || (n_ldac - l0) != 2) begin
            failures++;
            $display("FAIL t2_ldac_reload: dac=%h strobes=%0d, need a5c3/2", dac_out, n_ldac - l0);
        end
    endtask

    task automatic test_bad_frames();
        int e0, v0;
        e0 = n_err;
        v0 = n_valid;
        shift_bits(32'h1FFF, 15);
        end_frame();
        checks++;
        if ((n_err - e0) != 1) begin
            failures++;
            $display("FAIL t3_short_err: err pulses=%0d, need 1", n_err - e0);
        end
        shift_bits(32'h1FFFF, 17);
        end_frame();
        checks++;
        if ((n_err - e0) != 2 || (n_valid - v0) != 0) begin
            failures++;
            $display("FAIL t3_overrun_err: err=%0d valid=%0d, need 2/0", n_err - e0, n_valid - v0);
        end
        checks++;
        if (rx_data !== 16'hA5C3 || frame_cnt !== 4'd1) begin
            failures++;
            $display("FAIL t3_unchanged: rx=%h cnt=%0d, need a5c3/1", rx_data, frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = n_err;
        shift_bits(32'h12, 8);
        rst = 1'b1;
        bus.bCS = 1'b1;
        clks(2);
        checks++;
        if ({rx_data, dac_out, frame_cnt, rx_valid, ldac_strobe, frame_err} !== '0) begin
            failures++;
            $display("FAIL t4_in_reset: rx=%h dac=%h cnt=%0d, need all 0", rx_data, dac_out, frame_cnt);
        end
        rst = 1'b0;
        clks(6);
        shift_bits(32'h1234, 16);
        end_frame();
        checks++;
        if (rx_data !== 16'h1234 || frame_cnt !== 4'd1) begin
            failures++;
            $display("FAIL t4_clean_frame: rx=%h cnt=%0d, need 1234/1", rx_data, frame_cnt);
        end
        checks++;
        if ((n_err - e0) != 0) begin
            failures++;
            $display("FAIL t4_no_err: err pulses=%0d, need 0", n_err - e0);
        end
    endtask

    task automatic test_same_edge();
        logic both;
        both = 1'b0;
        shift_bits(32'hBEEF, 16);
        bus.bCS   = 1'b1;
        bus.bLDAC = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (rx_valid && ldac_strobe) both = 1'b1;
        end
        checks++;
        if (both !== 1'b1) begin
            failures++;
            $display("FAIL t5_coincident: rx_valid and ldac_strobe together=%b, need 1", both);
        end
        checks++;
        if (dac_out !== 16'hBEEF || rx_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL t5_bypass: dac=%h rx=%h, need beef/beef", dac_out, rx_data);
        end
        @(negedge clk);
        bus.bLDAC = 1'b1;
        clks(8);
    endtask

    task automatic test_cnt_wrap();
        int e0;
        do_reset();
        e0 = n_err;
        for (int f = 0; f < 16; f++) begin
            shift_bits(32'h0F00 + f, 16);
            end_frame();
            if (f == 14) begin
                checks++;
                if (frame_cnt !== 4'd15) begin
                    failures++;
                    $display("FAIL t6_before_wrap: cnt=%0d, need 15", frame_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 4'd0) begin
            failures++;
            $display("FAIL t6_wrap: cnt=%0d, need 0", frame_cnt);
        end
        checks++;
        if ((n_err - e0) != 0 || rx_data !== 16'h0F0F) begin
            failures++;
            $display("FAIL t6_clean: err=%0d rx=%h, need 0/0f0f", n_err - e0, rx_data);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.bCS   = 1'b1;
        bus.SCK   = 1'b0;
        bus.SDI   = 1'b0;
        bus.bLDAC = 1'b1;
        clks(2);
        test_reset();
        test_good_frame();
        test_ldac();
        test_bad_frames();
        test_reset_midframe();
        test_same_edge();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
